// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory pins.
// The arbiter uses the slave view; the requesters and memory use the master view.
interface mem_arbiter_if #(
  parameter int SIZE = 32
);
  logic            req0, req1;
  logic            we0, we1;
  logic [SIZE-1:0] addr0, addr1;
  logic [SIZE-1:0] wdata0, wdata1;
  logic            ack0, ack1;
  logic            err0, err1;
  logic [SIZE-1:0] rdata0, rdata1;
  logic            busy;
  logic            memRead, memWrite;
  logic [SIZE-1:0] address;
  logic [SIZE-1:0] WriteData;
  logic [SIZE-1:0] ReadData;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadData,
    output ack0, ack1, err0, err1, rdata0, rdata1, busy,
           memRead, memWrite, address, WriteData
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadData,
    input  ack0, ack1, err0, err1, rdata0, rdata1, busy,
           memRead, memWrite, address, WriteData
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared single-port data memory:
// one word access per grant, illegal addresses rejected without a strobe.
module mem_arbiter #(
  parameter int SIZE      = 32,
  parameter int MEM_BYTES = 2001
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  // state  | meaning
  // IDLE   | waiting for a request; arbitration happens at the edge leaving it
  // ACCESS | one strobe cycle on the memory pins
  // DONE   | one-cycle ack (with err) to the granted port
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic            last_grant, lat_we, lat_id, lat_err;
  logic            win, win_we, win_legal, grant;
  logic            we_nxt, id_nxt, err_nxt;
  logic [SIZE-1:0] win_addr, win_wdata;
  logic [SIZE:0]   win_end;
  logic [SIZE-1:0] address_q, wdata_q, rdata0_q, rdata1_q;
  logic            ack0_q, ack1_q, err0_q, err1_q, rd_q, wr_q;

  always_comb begin
    win       = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
    win_we    = win ? bus.we1    : bus.we0;
    win_addr  = win ? bus.addr1  : bus.addr0;
    win_wdata = win ? bus.wdata1 : bus.wdata0;
    // one extra bit so an address near the top wraps into "out of range"
    win_end   = {1'b0, win_addr} + (SIZE+1)'(SIZE/8 - 1);
    win_legal = (win_addr[1:0] == 2'b00) && (win_end <= (SIZE+1)'(MEM_BYTES - 1));
    grant     = (state == IDLE) && (bus.req0 || bus.req1);
    we_nxt    = grant ? win_we     : lat_we;
    id_nxt    = grant ? win        : lat_id;
    err_nxt   = grant ? !win_legal : lat_err;

    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = win_legal ? ACCESS : DONE;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_id     <= 1'b0;
      lat_err    <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      if (grant) begin
        lat_we     <= win_we;
        lat_id     <= win;
        lat_err    <= !win_legal;
        last_grant <= win;
        // memory pins keep their previous value across rejected accesses
        if (win_legal) begin
          address_q <= win_addr;
          wdata_q   <= win_wdata;
        end
      end
      if (state == ACCESS && !lat_we) begin
        if (lat_id) rdata1_q <= bus.ReadData;
        else        rdata0_q <= bus.ReadData;
      end
      ack0_q <= (state_nxt == DONE) && !id_nxt;
      ack1_q <= (state_nxt == DONE) &&  id_nxt;
      err0_q <= (state_nxt == DONE) && !id_nxt && err_nxt;
      err1_q <= (state_nxt == DONE) &&  id_nxt && err_nxt;
      rd_q   <= (state_nxt == ACCESS) && !we_nxt;
      wr_q   <= (state_nxt == ACCESS) &&  we_nxt;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = (state != IDLE);
  assign bus.memRead   = rd_q;
  assign bus.memWrite  = wr_q;
  assign bus.address   = address_q;
  assign bus.WriteData = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases plus two random requesters checked
// against a word-level model of the memory and the arbitration rules.
module tb_mem_arbiter;
  localparam int SIZE      = 32;
  localparam int MEM_BYTES = 2001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.SIZE(SIZE)) bus ();
  mem_arbiter #(.SIZE(SIZE), .MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rand_done = 1'b0;

  logic [7:0]  mem [0:MEM_BYTES-1];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] exp_rd [2];

  always @(posedge clk) cyc <= cyc + 1;

  // byte-addressed big-endian memory; write commits at the edge closing the strobe cycle
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    mem[3] = 8'd9;
    mem[7] = 8'd8;
    forever begin
      @(posedge clk);
      if (bus.memWrite && bus.address <= 32'(MEM_BYTES - 4))
        for (int i = 0; i < 4; i++) mem[bus.address + 32'(i)] = bus.WriteData[31-8*i -: 8];
    end
  end

  always_comb begin
    bus.ReadData = '0;
    if (bus.memRead && bus.address <= 32'(MEM_BYTES - 4))
      bus.ReadData = {mem[bus.address], mem[bus.address + 32'd1],
                      mem[bus.address + 32'd2], mem[bus.address + 32'd3]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (longint'(a) + 3 < MEM_BYTES);
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 32'h0;
  endfunction

  function automatic logic ack_of(input int p);
    return (p == 1) ? bus.ack1 : bus.ack0;
  endfunction

  function automatic logic err_of(input int p);
    return (p == 1) ? bus.err1 : bus.err0;
  endfunction

  function automatic logic [31:0] rdata_of(input int p);
    return (p == 1) ? bus.rdata1 : bus.rdata0;
  endfunction

  task automatic set_req(input int p, input bit v, input bit we, input logic [31:0] a,
                         input logic [31:0] d);
    if (p == 1) begin
      bus.req1 = v; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = v; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  // single uncontested transaction with latency, strobe and result checks
  task automatic run_txn(input string tag, input int p, input bit we, input logic [31:0] a,
                         input logic [31:0] d);
    int strobes = 0;
    int lat     = 0;
    bit got     = 1'b0;
    bit ok      = legal(a);
    set_req(p, 1'b1, we, a, d);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (ack_of(p)) begin
        got = 1'b1;
        lat = k;
        break;
      end
      if (bus.memRead || bus.memWrite) begin
        strobes++;
        check({tag, "_addr"}, bus.address, a);
        check({tag, "_wr"}, 32'(bus.memWrite), 32'(we));
        if (we) check({tag, "_wdata"}, bus.WriteData, d);
      end
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    check({tag, "_lat"}, lat, ok ? 2 : 1);
    check({tag, "_nstrobe"}, strobes, ok ? 1 : 0);
    check({tag, "_err"}, 32'(err_of(p)), 32'(!ok));
    check({tag, "_other_ack"}, 32'(ack_of(1 - p)), 32'd0);
    if (ok && we)  shadow[a] = d;
    if (ok && !we) exp_rd[p] = shadow_rd(a);
    check({tag, "_rdata"}, rdata_of(p), exp_rd[p]);
    set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r <= 5) return 32'(4 * $urandom_range(0, 15));
    if (r == 6) return 32'd1996;
    if (r == 7) return ($urandom_range(0, 1) == 1) ? 32'd1998 : 32'd2000;
    if (r == 8) return 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
    return 32'hFFFF_FFFC;
  endfunction

  task automatic drv(input int p);
    for (int t = 0; t < 30; t++) begin
      int          idle = $urandom_range(0, 3);
      bit          we   = 1'($urandom_range(0, 1));
      logic [31:0] a    = rand_addr();
      logic [31:0] d    = $urandom;
      bit          got  = 1'b0;
      repeat (idle) tick();
      set_req(p, 1'b1, we, a, d);
      for (int k = 0; k < 14; k++) begin
        tick();
        if (ack_of(p)) begin
          got = 1'b1;
          break;
        end
      end
      check("rnd_ack", 32'(got), 32'd1);
      if (got) begin
        check("rnd_err", 32'(err_of(p)), 32'(!legal(a)));
        if (legal(a) && we)  shadow[a] = d;
        if (legal(a) && !we) exp_rd[p] = shadow_rd(a);
        check("rnd_rdata", rdata_of(p), exp_rd[p]);
      end
      set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lg;
    bit got;
    bit seen_ack;
    int last;
    int t1;
    int expp;

    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    shadow[0] = 32'd9;
    shadow[4] = 32'd8;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    tick();
    tick();

    check("rst_ack", {bus.ack0, bus.ack1, bus.err0, bus.err1}, 32'h0);
    check("rst_strobe", {bus.busy, bus.memRead, bus.memWrite}, 32'h0);
    check("rst_address", bus.address, 32'h0);
    check("rst_wdata", bus.WriteData, 32'h0);
    check("rst_rdata0", bus.rdata0, 32'h0);
    check("rst_rdata1", bus.rdata1, 32'h0);

    // contention straight out of reset: port 0 goes first
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'd0, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'd4, 32'h0);
    tick();
    check("cont_addr0", bus.address, 32'd0);
    check("cont_busy", 32'(bus.busy), 32'd1);
    tick();
    check("cont_ack", {bus.ack0, bus.ack1}, 32'b10);
    exp_rd[0] = shadow_rd(0);
    check("cont_rdata0", bus.rdata0, exp_rd[0]);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("cont_idle", 32'(bus.busy), 32'd0);
    tick();
    check("cont_addr1", bus.address, 32'd4);
    tick();
    check("cont_ack1", {bus.ack0, bus.ack1}, 32'b01);
    exp_rd[1] = shadow_rd(4);
    check("cont_rdata1", bus.rdata1, exp_rd[1]);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    run_txn("single_rd", 0, 1'b0, 32'd4, 32'h0);
    lg = 1'b0;

    // both held high: grants alternate away from the last winner
    set_req(0, 1'b1, 1'b0, 32'd0, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'd4, 32'h0);
    last = cyc;
    for (int g = 0; g < 3; g++) begin
      expp = lg ? 0 : 1;
      got  = 1'b0;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (bus.ack0 || bus.ack1) begin
          got = 1'b1;
          break;
        end
      end
      check("alt_ack", 32'(got), 32'd1);
      check("alt_port", 32'(bus.ack1), expp);
      check("alt_gap", cyc - last, (g == 0) ? 2 : 3);
      exp_rd[expp] = shadow_rd((expp == 1) ? 32'd4 : 32'd0);
      check("alt_rdata", rdata_of(expp), exp_rd[expp]);
      last = cyc;
      lg   = 1'(expp);
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    run_txn("wr8", 1, 1'b1, 32'd8, 32'h0000_ABCD);
    run_txn("rd8", 1, 1'b0, 32'd8, 32'h0);
    check("rd8_rdata0_kept", bus.rdata0, exp_rd[0]);

    run_txn("mis2", 0, 1'b0, 32'd2, 32'h0);
    run_txn("oor1998", 1, 1'b0, 32'd1998, 32'h0);
    run_txn("wrap", 1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    run_txn("edge1996_wr", 1, 1'b1, 32'd1996, 32'h1234_5678);
    run_txn("edge1996_rd", 1, 1'b0, 32'd1996, 32'h0);
    run_txn("oor_wr2000", 0, 1'b1, 32'd2000, 32'hDEAD_BEEF);

    // back-to-back: port 1 re-requests right after its ack while port 0 waits
    set_req(1, 1'b1, 1'b0, 32'd0, 32'h0);
    tick();
    set_req(0, 1'b1, 1'b0, 32'd4, 32'h0);
    tick();
    check("b2b_ack1", {bus.ack0, bus.ack1}, 32'b01);
    t1 = cyc;
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    set_req(1, 1'b1, 1'b0, 32'd8, 32'h0);
    tick();
    check("b2b_addr_p0", bus.address, 32'd4);
    tick();
    check("b2b_ack0", {bus.ack0, bus.ack1}, 32'b10);
    check("b2b_gap0", cyc - t1, 3);
    exp_rd[0] = shadow_rd(4);
    check("b2b_rdata0", bus.rdata0, exp_rd[0]);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    check("b2b_ack1b", {bus.ack0, bus.ack1}, 32'b01);
    check("b2b_gap1", cyc - t1, 6);
    exp_rd[1] = shadow_rd(8);
    check("b2b_rdata1", bus.rdata1, exp_rd[1]);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // reset in the middle of a write strobe: no commit, no ack
    set_req(0, 1'b1, 1'b1, 32'd12, 32'h55AA_55AA);
    tick();
    check("rstmid_wr", 32'(bus.memWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_strobe", {bus.busy, bus.memRead, bus.memWrite, bus.ack0, bus.ack1}, 32'h0);
    check("rstmid_address", bus.address, 32'h0);
    check("rstmid_wdata", bus.WriteData, 32'h0);
    check("rstmid_rdata", {bus.rdata0 | bus.rdata1}, 32'h0);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    seen_ack = 1'b0;
    repeat (4) begin
      tick();
      seen_ack = seen_ack | bus.ack0 | bus.ack1;
    end
    check("rstmid_no_ack", 32'(seen_ack), 32'd0);
    check("rstmid_no_commit", {mem[12], mem[13], mem[14], mem[15]}, shadow_rd(12));

    fork
      begin
        fork
          drv(0);
          drv(1);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          if (bus.ack0 || bus.ack1) check("ack_excl", 32'(bus.ack0 & bus.ack1), 32'd0);
        end
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
